// File: rtl/tmr_cnt_if.sv
// Register-file side bundle of the timer core: TCR/TDR/TCMP/TIER/TISR fields
// in, counter value, tick and interrupt status out.
interface tmr_cnt_if #(
    parameter int CNT_W = 64
);
    logic               timer_en;
    logic               div_en;
    logic [3:0]         div_val;
    logic               cnt_wr_lo;
    logic               cnt_wr_hi;
    logic [CNT_W/2-1:0] wr_data;
    logic [CNT_W-1:0]   cmp_val;
    logic               int_en;
    logic               int_clr;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_tick;
    logic               int_st;
    logic               irq;

    modport master (
        output timer_en, div_en, div_val, cnt_wr_lo, cnt_wr_hi, wr_data,
               cmp_val, int_en, int_clr,
        input  cnt_val, cnt_tick, int_st, irq
    );

    modport slave (
        input  timer_en, div_en, div_val, cnt_wr_lo, cnt_wr_hi, wr_data,
               cmp_val, int_en, int_clr,
        output cnt_val, cnt_tick, int_st, irq
    );
endinterface

// File: rtl/tmr_cnt_core.sv
// Timer core: power-of-two prescaler, 64-bit loadable free-running counter,
// sticky compare-match status and maskable irq.
module tmr_cnt_core #(
    parameter int CNT_W = 64
) (
    input  logic      clk,
    input  logic      rst,
    tmr_cnt_if.slave  bus
);
    localparam int HALF = CNT_W / 2;

    logic [7:0]       pre_cnt_q, pre_cnt_d;
    logic [7:0]       pre_max;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             int_st_q, int_st_d;
    logic             div_mode, pre_wrap, tick_c, wr_any, match;

    // All-ones mask of div_val bits: (1<<div_val)-1 for div_val in 1..8.
    assign pre_max  = 8'hFF >> (4'd8 - bus.div_val);
    assign div_mode = bus.div_en && (bus.div_val != 4'd0);
    assign pre_wrap = pre_cnt_q == pre_max;
    assign tick_c   = bus.timer_en && (!div_mode || pre_wrap);
    assign wr_any   = bus.cnt_wr_lo || bus.cnt_wr_hi;
    assign match    = cnt_q == bus.cmp_val;

    always_comb begin
        pre_cnt_d = pre_cnt_q + 8'd1;
        if (!bus.timer_en || !div_mode || pre_wrap)
            pre_cnt_d = 8'd0;
    end

    // A write wins over the tick; the unwritten half holds its value.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_any) begin
            if (bus.cnt_wr_lo) cnt_d[HALF-1:0]     = bus.wr_data;
            if (bus.cnt_wr_hi) cnt_d[CNT_W-1:HALF] = bus.wr_data;
        end else if (tick_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tick_d   = tick_c && !wr_any;
    assign int_st_d = match || (int_st_q && !bus.int_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= 8'd0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            int_st_q  <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            int_st_q  <= int_st_d;
        end
    end

    assign bus.cnt_val  = cnt_q;
    assign bus.cnt_tick = tick_q;
    assign bus.int_st   = int_st_q;
    assign bus.irq      = int_st_q & bus.int_en;
endmodule

// File: tb/tb_tmr_cnt_core.sv
// Directed bench for tmr_cnt_core: cycle-by-cycle comparison against a
// period/elapsed-time model plus literal checkpoints from the test plan.
module tb_tmr_cnt_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    tmr_cnt_if #(.CNT_W(64)) b ();

    tmr_cnt_core #(.CNT_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    // Model: a tick falls every period-th cycle of continuous enable.
    logic [63:0] m_cnt;
    logic        m_tick, m_st;
    int          m_el, m_per;
    logic        m_tick_c, m_wr;

    assign m_per    = !b.timer_en ? 0 :
                      (b.div_en && b.div_val != 4'd0) ? (1 << b.div_val) : 1;
    assign m_tick_c = (m_per != 0) && (((m_el + 1) % m_per) == 0);
    assign m_wr     = b.cnt_wr_lo || b.cnt_wr_hi;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= '0;
            m_tick <= 1'b0;
            m_st   <= 1'b0;
            m_el   <= 0;
        end else begin
            m_el   <= b.timer_en ? m_el + 1 : 0;
            m_tick <= m_tick_c && !m_wr;
            m_st   <= (m_cnt == b.cmp_val) || (m_st && !b.int_clr);
            if (m_wr)
                m_cnt <= {b.cnt_wr_hi ? b.wr_data : m_cnt[63:32],
                          b.cnt_wr_lo ? b.wr_data : m_cnt[31:0]};
            else
                m_cnt <= m_cnt + (m_tick_c ? 64'd1 : 64'd0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_chk += 4;
            if (b.cnt_val !== m_cnt) begin
                n_fail++;
                $display("FAIL model cnt_val: got %h want %h at %0t", b.cnt_val, m_cnt, $time);
            end
            if (b.cnt_tick !== m_tick) begin
                n_fail++;
                $display("FAIL model cnt_tick: got %b want %b at %0t", b.cnt_tick, m_tick, $time);
            end
            if (b.int_st !== m_st) begin
                n_fail++;
                $display("FAIL model int_st: got %b want %b at %0t", b.int_st, m_st, $time);
            end
            if (b.irq !== (m_st & b.int_en)) begin
                n_fail++;
                $display("FAIL model irq: got %b want %b at %0t", b.irq, m_st & b.int_en, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic lo, input logic hi, input logic [31:0] d);
        b.cnt_wr_lo = lo;
        b.cnt_wr_hi = hi;
        b.wr_data   = d;
        cyc(1);
        b.cnt_wr_lo = 1'b0;
        b.cnt_wr_hi = 1'b0;
    endtask

    initial begin
        b.timer_en = 0; b.div_en = 0; b.div_val = 0;
        b.cnt_wr_lo = 0; b.cnt_wr_hi = 0; b.wr_data = 0;
        b.cmp_val = '1; b.int_en = 0; b.int_clr = 0;
        cyc(2);
        rst = 0;
        chk("reset cnt_val", b.cnt_val, 64'd0);
        chk("reset cnt_tick", 64'(b.cnt_tick), 64'd0);
        chk("reset int_st", 64'(b.int_st), 64'd0);
        chk("reset irq", 64'(b.irq), 64'd0);

        // Bypass
        b.timer_en = 1;
        cyc(10);
        chk("bypass cnt_val", b.cnt_val, 64'd10);
        chk("bypass cnt_tick", 64'(b.cnt_tick), 64'd1);
        chk("bypass int_st", 64'(b.int_st), 64'd0);
        b.timer_en = 0;
        wr(1, 1, 32'd0);

        // Prescale by 8, then by 256
        b.div_en = 1; b.div_val = 3; b.timer_en = 1;
        cyc(7);
        chk("div8 before first tick", b.cnt_val, 64'd0);
        cyc(57);
        chk("div8 cnt_val", b.cnt_val, 64'd8);
        b.timer_en = 0;
        wr(1, 1, 32'd0);
        b.div_val = 8; b.timer_en = 1;
        cyc(512);
        chk("div256 cnt_val", b.cnt_val, 64'd2);
        b.timer_en = 0;

        // Wrap at all ones (also matches the all-ones compare value)
        b.div_en = 0;
        wr(0, 1, 32'hFFFF_FFFF);
        wr(1, 0, 32'hFFFF_FFFE);
        chk("wrap preload", b.cnt_val, 64'hFFFF_FFFF_FFFF_FFFE);
        b.timer_en = 1;
        cyc(1);
        chk("wrap all ones", b.cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1);
        chk("wrap to zero", b.cnt_val, 64'd0);
        chk("wrap match status", 64'(b.int_st), 64'd1);
        b.int_clr = 1;
        cyc(1);
        b.int_clr = 0;
        chk("clear after wrap", 64'(b.int_st), 64'd0);

        // Write vs tick
        b.timer_en = 0;
        wr(1, 1, 32'd0);
        wr(1, 0, 32'h5);
        b.timer_en = 1; b.cnt_wr_lo = 1; b.wr_data = 32'h100;
        cyc(1);
        b.cnt_wr_lo = 0;
        chk("write beats tick", b.cnt_val, 64'h100);
        cyc(1);
        chk("tick after write", b.cnt_val, 64'h101);
        b.timer_en = 0;

        // Interrupt
        wr(1, 1, 32'd0);
        b.cmp_val = 64'd20; b.int_en = 1; b.timer_en = 1;
        cyc(20);
        chk("match cycle cnt", b.cnt_val, 64'd20);
        chk("match cycle int_st", 64'(b.int_st), 64'd0);
        cyc(1);
        chk("int_st after match", 64'(b.int_st), 64'd1);
        chk("irq after match", 64'(b.irq), 64'd1);
        b.int_clr = 1;
        cyc(1);
        b.int_clr = 0;
        chk("clear no match", 64'(b.int_st), 64'd0);
        b.timer_en = 0;
        wr(1, 0, 32'd20);
        b.int_clr = 1;
        cyc(1);
        b.int_clr = 0;
        chk("set beats clear", 64'(b.int_st), 64'd1);
        b.int_en = 0;
        cyc(1);
        chk("masked int_st", 64'(b.int_st), 64'd1);
        chk("masked irq", 64'(b.irq), 64'd0);

        // Async reset mid-count
        b.cmp_val = '1; b.int_en = 1;
        wr(1, 1, 32'd0);
        b.div_en = 1; b.div_val = 2; b.timer_en = 1;
        cyc(10);
        chk("div4 cnt_val", b.cnt_val, 64'd2);
        #1 rst = 1;
        #1;
        chk("async cnt_val", b.cnt_val, 64'd0);
        chk("async int_st", 64'(b.int_st), 64'd0);
        chk("async irq", 64'(b.irq), 64'd0);
        chk("async cnt_tick", 64'(b.cnt_tick), 64'd0);
        cyc(1);
        rst = 0;
        cyc(3);
        chk("prescaler restarted", b.cnt_val, 64'd0);
        cyc(1);
        chk("first tick after reset", b.cnt_val, 64'd1);
        b.timer_en = 0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
